// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Merges memory wait, branch flush and load-use hazard into stage controls.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_access,
  input  logic                 mem_ready,
  output logic                 freeze_if,
  output logic                 freeze_id,
  output logic                 bubble_id_exe,
  output logic                 flush_if_id,
  output logic                 freeze_exe_mem,
  output logic                 mem_wait,
  output logic                 mem_timeout_err,
  output logic [CNT_WIDTH-1:0] hazard_stall_cnt,
  output logic [CNT_WIDTH-1:0] mem_stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          err_q, err_d;

  logic [CNT_WIDTH-1:0] haz_cnt_q, haz_cnt_d;
  logic [CNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
  logic [CNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;

  logic mem_freeze;
  logic pri_mem;
  logic pri_br;
  logic pri_haz;

  assign mem_freeze = mem_access & ~mem_ready;
  assign pri_mem    = mem_freeze;
  assign pri_br     = ~mem_freeze & branch_taken;
  assign pri_haz    = ~mem_freeze & ~branch_taken
                    & hazard_detected;

  // Zero-latency stage controls, memory beats branch beats hazard
  always_comb begin
    freeze_if      = 1'b0;
    freeze_id      = 1'b0;
    freeze_exe_mem = 1'b0;
    bubble_id_exe  = 1'b0;
    flush_if_id    = 1'b0;
    unique case (1'b1)
      pri_mem: begin
        freeze_if      = 1'b1;
        freeze_id      = 1'b1;
        freeze_exe_mem = 1'b1;
      end
      pri_br: begin
        flush_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end
      pri_haz: begin
        freeze_if     = 1'b1;
        bubble_id_exe = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state: leave MEM_WAIT on the first ready cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (mem_freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)  state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Consecutive stall-cycle count and sticky timeout flag
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!mem_freeze)
      wait_cnt_d = '0;
    else if (wait_cnt_q != TMO)
      wait_cnt_d = wait_cnt_q + WW'(1);
    err_d = err_q | (wait_cnt_d == TMO);
  end

  // Saturating event counters keyed to the active priority term
  always_comb begin
    haz_cnt_d = haz_cnt_q;
    mem_cnt_d = mem_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    if (pri_haz && haz_cnt_q != CMAX)
      haz_cnt_d = haz_cnt_q + CNT_WIDTH'(1);
    if (pri_mem && mem_cnt_q != CMAX)
      mem_cnt_d = mem_cnt_q + CNT_WIDTH'(1);
    if (pri_br && fl_cnt_q != CMAX)
      fl_cnt_d = fl_cnt_q + CNT_WIDTH'(1);
  end

  // State, wait tracking and counters with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      haz_cnt_q  <= '0;
      mem_cnt_q  <= '0;
      fl_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      haz_cnt_q  <= haz_cnt_d;
      mem_cnt_q  <= mem_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  assign mem_wait         = (state_q == MEM_WAIT);
  assign mem_timeout_err  = err_q;
  assign hazard_stall_cnt = haz_cnt_q;
  assign mem_stall_cnt    = mem_cnt_q;
  assign flush_cnt        = fl_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller.
// Small timeout and counter width exercise saturation quickly.
module tb_pipeline_stall_controller;

  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst;
  logic hazard_detected;
  logic branch_taken;
  logic mem_access;
  logic mem_ready;
  logic freeze_if;
  logic freeze_id;
  logic bubble_id_exe;
  logic flush_if_id;
  logic freeze_exe_mem;
  logic mem_wait;
  logic mem_timeout_err;
  logic [CW-1:0] hazard_stall_cnt;
  logic [CW-1:0] mem_stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [4:0] ctrl;

  int checks = 0;
  int passed = 0;

  assign ctrl = {freeze_if, freeze_id, freeze_exe_mem,
                 bubble_id_exe, flush_if_id};

  pipeline_stall_controller #(
    .MEM_TIMEOUT(4),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hazard_detected(hazard_detected),
    .branch_taken(branch_taken),
    .mem_access(mem_access),
    .mem_ready(mem_ready),
    .freeze_if(freeze_if),
    .freeze_id(freeze_id),
    .bubble_id_exe(bubble_id_exe),
    .flush_if_id(flush_if_id),
    .freeze_exe_mem(freeze_exe_mem),
    .mem_wait(mem_wait),
    .mem_timeout_err(mem_timeout_err),
    .hazard_stall_cnt(hazard_stall_cnt),
    .mem_stall_cnt(mem_stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_access = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_access = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (mem_wait !== 1'b0)
      $display("FAIL reset_wait got=%b exp=0", mem_wait);
    else passed++;
    checks++;
    if ({hazard_stall_cnt, mem_stall_cnt, flush_cnt} !== '0)
      $display("FAIL reset_cnts got=%h/%h/%h exp=0",
               hazard_stall_cnt, mem_stall_cnt, flush_cnt);
    else passed++;
    checks++;
    if (mem_timeout_err !== 1'b0)
      $display("FAIL reset_err got=%b exp=0", mem_timeout_err);
    else passed++;
    tick();
    checks++;
    if (mem_wait !== 1'b1)
      $display("FAIL reset_next_wait got=%b exp=1", mem_wait);
    else passed++;
    mem_access = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    hazard_detected = 1'b1;
    #1;
    checks++;
    if (ctrl !== 5'b10010)
      $display("FAIL lu_ctrl got=%b exp=10010", ctrl);
    else passed++;
    tick();
    hazard_detected = 1'b0;
    checks++;
    if (hazard_stall_cnt !== 3'd1)
      $display("FAIL lu_cnt got=%0d exp=1", hazard_stall_cnt);
    else passed++;
  endtask

  task automatic test_branch_over_hazard();
    hazard_detected = 1'b1;
    branch_taken = 1'b1;
    #1;
    checks++;
    if (ctrl !== 5'b00011)
      $display("FAIL br_ctrl got=%b exp=00011", ctrl);
    else passed++;
    tick();
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (flush_cnt !== 3'd1)
      $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt);
    else passed++;
    checks++;
    if (hazard_stall_cnt !== 3'd1)
      $display("FAIL br_haz_cnt got=%0d exp=1",
               hazard_stall_cnt);
    else passed++;
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_access = 1'b1;
    mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      hazard_detected = (i == 3);
      branch_taken = (i == 3);
      #1;
      checks++;
      if (ctrl !== 5'b11100)
        $display("FAIL mw_ctrl c%0d got=%b exp=11100", i, ctrl);
      else passed++;
      checks++;
      if (mem_wait !== (i > 1))
        $display("FAIL mw_state c%0d got=%b exp=%b",
                 i, mem_wait, (i > 1));
      else passed++;
      tick();
    end
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl !== 5'b00000 || mem_wait !== 1'b1)
      $display("FAIL mw_release got=%b/%b exp=00000/1",
               ctrl, mem_wait);
    else passed++;
    tick();
    mem_access = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (mem_wait !== 1'b0)
      $display("FAIL mw_run got=%b exp=0", mem_wait);
    else passed++;
    checks++;
    if (mem_stall_cnt !== 3'd5)
      $display("FAIL mw_cnt got=%0d exp=5", mem_stall_cnt);
    else passed++;
    checks++;
    if (flush_cnt !== 3'd0 || hazard_stall_cnt !== 3'd0)
      $display("FAIL mw_other got=%0d/%0d exp=0/0",
               flush_cnt, hazard_stall_cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1;
    mem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (mem_timeout_err !== (i >= 4))
        $display("FAIL to_err e%0d got=%b exp=%b",
                 i, mem_timeout_err, (i >= 4));
      else passed++;
    end
    mem_ready = 1'b1;
    tick();
    mem_access = 1'b0;
    mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_timeout_err !== 1'b1 || mem_wait !== 1'b0)
      $display("FAIL to_sticky got=%b/%b exp=1/0",
               mem_timeout_err, mem_wait);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mem_timeout_err !== 1'b0)
      $display("FAIL to_clear got=%b exp=0", mem_timeout_err);
    else passed++;
  endtask

  task automatic test_saturation_reset();
    do_reset();
    hazard_detected = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (hazard_stall_cnt !== CW'((i < 7) ? i : 7))
        $display("FAIL sat_cnt e%0d got=%0d exp=%0d",
                 i, hazard_stall_cnt, (i < 7) ? i : 7);
      else passed++;
    end
    hazard_detected = 1'b0;
    mem_access = 1'b1;
    mem_ready = 1'b0;
    tick();
    checks++;
    if (mem_wait !== 1'b1 || mem_stall_cnt !== 3'd1)
      $display("FAIL sat_wait got=%b/%0d exp=1/1",
               mem_wait, mem_stall_cnt);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_access = 1'b0;
    checks++;
    if (mem_wait !== 1'b0)
      $display("FAIL midrst_state got=%b exp=0", mem_wait);
    else passed++;
    checks++;
    if ({hazard_stall_cnt, mem_stall_cnt, flush_cnt} !== '0)
      $display("FAIL midrst_cnts got=%0d/%0d/%0d exp=0",
               hazard_stall_cnt, mem_stall_cnt, flush_cnt);
    else passed++;
  endtask

  task automatic test_ready_idle();
    do_reset();
    mem_access = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ctrl !== 5'b00000)
      $display("FAIL idle_ctrl got=%b exp=00000", ctrl);
    else passed++;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (mem_wait !== 1'b0 || mem_stall_cnt !== 3'd0)
      $display("FAIL idle_state got=%b/%0d exp=0/0",
               mem_wait, mem_stall_cnt);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    hazard_detected = 1'b0;
    branch_taken = 1'b0;
    mem_access = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_branch_over_hazard();
    test_mem_wait();
    test_timeout();
    test_saturation_reset();
    test_ready_idle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
